// File: rtl/wb_flash_arb.sv
// wb_flash_arb: two-master Wishbone arbiter in front of a read-only SPI flash slave.
// Writes are answered locally and never reach the slave.
module wb_flash_arb #(
    parameter bit FAIR      = 1'b1,
    parameter bit WRITE_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic [31:0] s_adr_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  gnt_o
);
    typedef enum logic [1:0] {IDLE, READ, WRESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [31:0] adr_q, adr_d;
    logic        req0, req1, pick1, we_sel, rd, wr;
    logic [31:0] adr_sel;
    logic        unused;

    assign req0    = m0_stb_i & m0_cyc_i;
    assign req1    = m1_stb_i & m1_cyc_i;
    // last_q=1 means m1 was served last, so on a fair tie m1 wins only when m0 went last
    assign pick1   = req1 & (!req0 | (FAIR & !last_q));
    assign we_sel  = pick1 ? m1_we_i : m0_we_i;
    assign adr_sel = pick1 ? m1_adr_i : m0_adr_i;
    assign unused  = ^{m0_dat_i, m0_sel_i, m1_dat_i, m1_sel_i, adr_sel[31:24]};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        adr_d   = adr_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                gnt_d   = pick1 ? 2'b10 : 2'b01;
                state_d = we_sel ? WRESP : READ;
                adr_d   = we_sel ? adr_q : {8'h00, adr_sel[23:0]};
            end
            READ: if (s_ack_i) begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            WRESP: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            adr_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
        end
    end

    assign rd       = state_q == READ;
    assign wr       = state_q == WRESP;
    assign s_adr_o  = adr_q;
    assign s_we_o   = 1'b0;
    assign s_sel_o  = 4'hF;
    assign s_stb_o  = rd;
    assign s_cyc_o  = rd;
    assign gnt_o    = gnt_q;
    assign m0_ack_o = gnt_q[0] & ((rd & s_ack_i) | (wr & !WRITE_ERR));
    assign m1_ack_o = gnt_q[1] & ((rd & s_ack_i) | (wr & !WRITE_ERR));
    assign m0_err_o = gnt_q[0] & wr & WRITE_ERR;
    assign m1_err_o = gnt_q[1] & wr & WRITE_ERR;
    assign m0_dat_o = (gnt_q[0] & rd & s_ack_i) ? s_dat_i : 32'h0;
    assign m1_dat_o = (gnt_q[1] & rd & s_ack_i) ? s_dat_i : 32'h0;
endmodule

// File: tb/tb_wb_flash_arb.sv
// tb_wb_flash_arb: scoreboard bench for wb_flash_arb; dut_a is FAIR=1/WRITE_ERR=1,
// dut_b is FAIR=0/WRITE_ERR=0, both share stimulus and sel picks the one observed.
module tb_wb_flash_arb;
    logic clk = 0, rst = 1, sel = 0;
    always #5 clk = ~clk;

    logic [31:0] m0_adr = 0, m1_adr = 0, s_dat = 0;
    logic        m0_we = 0, m0_stb = 0, m0_cyc = 0;
    logic        m1_we = 0, m1_stb = 0, m1_cyc = 0, s_ack = 0;

    logic [1:0]  ack_a, err_a, gnt_a, ack_b, err_b, gnt_b;
    logic [31:0] d0_a, d1_a, adr_a, d0_b, d1_b, adr_b;
    logic        we_a, stb_a, cyc_a, we_b, stb_b, cyc_b;
    logic [3:0]  sl_a, sl_b;

    wb_flash_arb #(.FAIR(1'b1), .WRITE_ERR(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(32'hA5A5A5A5), .m0_we_i(m0_we), .m0_sel_i(4'h3),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(ack_a[0]), .m0_err_o(err_a[0]), .m0_dat_o(d0_a),
        .m1_adr_i(m1_adr), .m1_dat_i(32'h5A5A5A5A), .m1_we_i(m1_we), .m1_sel_i(4'hC),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(ack_a[1]), .m1_err_o(err_a[1]), .m1_dat_o(d1_a),
        .s_adr_o(adr_a), .s_we_o(we_a), .s_sel_o(sl_a), .s_stb_o(stb_a), .s_cyc_o(cyc_a),
        .s_ack_i(s_ack), .s_dat_i(s_dat), .gnt_o(gnt_a)
    );

    wb_flash_arb #(.FAIR(1'b0), .WRITE_ERR(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(32'hA5A5A5A5), .m0_we_i(m0_we), .m0_sel_i(4'h3),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(ack_b[0]), .m0_err_o(err_b[0]), .m0_dat_o(d0_b),
        .m1_adr_i(m1_adr), .m1_dat_i(32'h5A5A5A5A), .m1_we_i(m1_we), .m1_sel_i(4'hC),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(ack_b[1]), .m1_err_o(err_b[1]), .m1_dat_o(d1_b),
        .s_adr_o(adr_b), .s_we_o(we_b), .s_sel_o(sl_b), .s_stb_o(stb_b), .s_cyc_o(cyc_b),
        .s_ack_i(s_ack), .s_dat_i(s_dat), .gnt_o(gnt_b)
    );

    logic [1:0]  ack, err, gnt;
    logic [31:0] d0, d1, s_adr;
    logic        s_we, s_stb, s_cyc;
    logic [3:0]  s_sel;
    assign ack   = sel ? ack_b : ack_a;
    assign err   = sel ? err_b : err_a;
    assign gnt   = sel ? gnt_b : gnt_a;
    assign d0    = sel ? d0_b : d0_a;
    assign d1    = sel ? d1_b : d1_a;
    assign s_adr = sel ? adr_b : adr_a;
    assign s_we  = sel ? we_b : we_a;
    assign s_sel = sel ? sl_b : sl_a;
    assign s_stb = sel ? stb_b : stb_a;
    assign s_cyc = sel ? cyc_b : cyc_a;

    typedef struct {logic m; logic err; logic [31:0] d;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] d;
        exp_t e;
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                d = m ? d1 : d0;
                if (ack[m] | err[m]) begin
                    if (q.size() == 0) chk("unexpected_resp", {ack, err, d}, 0);
                    else begin
                        e = q.pop_front();
                        chk("resp_master", m, e.m);
                        chk("resp_kind", {err[m], ack[m]}, {e.err, !e.err});
                        chk("resp_data", d, e.d);
                    end
                end else if (d != 0) chk("idle_data", d, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack} = 0;
        s_dat = 0;
    endtask

    task automatic do_rst();
        rst = 1;
        clr();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic outs_zero(input string n);
        chk({n, "_m"}, {ack, err, gnt, d0, d1}, 0);
        chk({n, "_s"}, {s_stb, s_cyc, s_we, s_sel}, {3'b000, 4'hF});
    endtask

    task automatic rd(input bit m, input logic [31:0] a);
        if (m) begin m1_adr = a; m1_we = 0; m1_stb = 1; m1_cyc = 1; end
        else begin m0_adr = a; m0_we = 0; m0_stb = 1; m0_cyc = 1; end
    endtask

    task automatic drop(input bit m);
        if (m) {m1_stb, m1_cyc, m1_we} = 0;
        else {m0_stb, m0_cyc, m0_we} = 0;
    endtask

    task automatic serve(input bit m, input logic [31:0] xa, input int lat, input logic [31:0] d);
        int t;
        t = 0;
        while (!s_stb && t < 100) begin tick(); t++; end
        chk("stb_seen", s_stb, 1);
        chk("gnt", gnt, m ? 2'b10 : 2'b01);
        chk("s_adr", s_adr, xa);
        repeat (lat) tick();
        q.push_back('{m, 1'b0, d});
        s_ack = 1;
        s_dat = d;
        tick();
        s_ack = 0;
        s_dat = 0;
        drop(m);
    endtask

    task automatic wr(input bit m, input logic [31:0] a, input bit xerr);
        if (m) begin m1_adr = a; m1_we = 1; m1_stb = 1; m1_cyc = 1; end
        else begin m0_adr = a; m0_we = 1; m0_stb = 1; m0_cyc = 1; end
        q.push_back('{m, xerr, 32'h0});
        tick();
        chk("wr_gnt", gnt, m ? 2'b10 : 2'b01);
        chk("wr_no_stb", {s_stb, s_cyc}, 0);
        tick();
        drop(m);
        chk("wr_no_stb2", {s_stb, s_cyc, gnt}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        do_rst();
        outs_zero("reset");
        chk("reset_adr", s_adr, 0);
        rd(0, 32'h0000_0100);
        serve(0, 32'h0000_0100, 40, 32'hDEADBEEF);
        // fair ties: fresh reset makes m0 win first, then alternation follows last served
        do_rst();
        rd(0, 32'h200); rd(1, 32'h300);
        serve(0, 32'h200, 3, 32'h11111111);
        serve(1, 32'h300, 2, 32'h22222222);
        rd(0, 32'h400);
        serve(0, 32'h400, 1, 32'h33333333);
        rd(0, 32'h500); rd(1, 32'h600);
        serve(1, 32'h600, 2, 32'h44444444);
        serve(0, 32'h500, 2, 32'h55555555);
        rd(0, 32'h700);
        tick();
        chk("mid_gnt0", gnt, 2'b01);
        rd(1, 32'h800);
        serve(0, 32'h700, 4, 32'h66666666);
        chk("mid_gnt_idle", gnt, 2'b00);
        tick();
        chk("mid_gnt1", gnt, 2'b10);
        serve(1, 32'h800, 1, 32'h77777777);
        wr(1, 32'h10, 1'b1);
        rd(0, 32'hFF12_3456);
        serve(0, 32'h0012_3456, 2, 32'h89ABCDEF);
        rd(0, 32'h900);
        tick();
        chk("pre_rst_stb", s_stb, 1);
        repeat (5) tick();
        rst = 1;
        #1;
        outs_zero("async_rst");
        drop(0);
        tick();
        rst = 0;
        rd(0, 32'hA00);
        serve(0, 32'hA00, 3, 32'hCAFEF00D);
        // fixed priority instance: m0 wins every tie, writes are acked
        rst = 1;
        sel = 1;
        do_rst();
        outs_zero("reset_b");
        rd(0, 32'hB00); rd(1, 32'hC00);
        serve(0, 32'hB00, 2, 32'h00000001);
        serve(1, 32'hC00, 2, 32'h00000002);
        rd(0, 32'hD00);
        serve(0, 32'hD00, 1, 32'h00000003);
        rd(0, 32'hE00); rd(1, 32'hF00);
        serve(0, 32'hE00, 2, 32'h00000004);
        serve(1, 32'hF00, 1, 32'h00000005);
        wr(1, 32'h10, 1'b0);
        tick();
        tick();
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_flash_arb.md
Name: wb_flash_arb

Overview:
Two-master Wishbone arbiter that shares the single read-only SPI flash instruction-memory slave between the instruction-fetch bus (m0) and the data-load bus (m1). It grants one master at a time and latches that master's address for the whole slave transaction. It routes the slave's ack and data back to the granted master only. Write attempts are answered locally and never reach the flash slave. The block sits between the core's two bus ports and the flash-memory Wishbone slave, and runs on the rising edge of clk.

Parameters:
FAIR, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority with m0 always winning.
WRITE_ERR, 1, 1 = write requests are answered with err; 0 = write requests are answered with ack and the write data is discarded.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
m0_adr_i  in  32  master 0 address
m0_dat_i  in  32  master 0 write data (ignored)
m0_we_i  in  1  master 0 write enable
m0_sel_i  in  4  master 0 byte select (ignored)
m0_stb_i  in  1  master 0 strobe
m0_cyc_i  in  1  master 0 cycle
m0_ack_o  out  1  master 0 acknowledge
m0_err_o  out  1  master 0 error (rejected write)
m0_dat_o  out  32  master 0 read data
m1_*  same set of ports as m0, for master 1
s_adr_o  out  32  address to flash slave
s_we_o  out  1  tied to 0
s_sel_o  out  4  tied to 4'hF
s_stb_o  out  1  strobe to flash slave
s_cyc_o  out  1  cycle to flash slave
s_ack_i  in  1  flash slave acknowledge
s_dat_i  in  32  flash slave read data
gnt_o  out  2  one-hot current grant; 0 when idle

Behaviour:
- Request definition: req_x = mx_stb_i & mx_cyc_i.
- Masters hold stb, adr and we stable until they receive ack or err, and drop stb on the edge after the response.
- Reset (asynchronous) values:
  - state = IDLE, gnt = 0, last = m1 (so m0 wins the first tie).
  - s_adr_o = 0, s_stb_o = s_cyc_o = 0.
  - All mx_ack_o, mx_err_o and mx_dat_o are 0.
- State IDLE:
  - No request: stay in IDLE.
  - Exactly one master requesting: grant that master.
  - Both requesting, FAIR=1: grant the master that is not in last.
  - Both requesting, FAIR=0: grant m0.
  - Granted request is a read: latch {8'h00, adr[23:0]} into s_adr_o and go to READ.
  - Granted request is a write: go to WRESP.
- State READ:
  - s_stb_o = s_cyc_o = 1.
  - Granted master's ack = s_ack_i, combinational. Its dat_o = s_dat_i while s_ack_i is high, otherwise 0.
  - On the edge where s_ack_i=1: last <= gnt, gnt <= 0, go to IDLE.
  - No timeout. READ waits indefinitely for s_ack_i.
  - The other master's ack, err and dat stay 0; its request stays pending.
- State WRESP:
  - For exactly one cycle, the granted master sees ack=1 (WRITE_ERR=0) or err=1 (WRITE_ERR=1). Its dat_o stays 0.
  - Next edge: last <= gnt, go to IDLE.
  - The slave is never strobed in this state.
- Latency:
  - Request visible before edge k -> grant registered at edge k -> s_stb_o high from edge k until the edge at which s_ack_i is sampled.
  - A write is answered in the cycle after edge k.
  - After any response, IDLE lasts at least one cycle before the next grant. Back-to-back reads therefore have at least one dead cycle, which lets the slave return to its own idle state.
- gnt_o mirrors gnt and reads 0 in IDLE.
- A master that drops stb while granted is protocol misuse. The arbiter still completes the slave transaction and returns to IDLE; the response is dropped.
- rst asserted mid-READ: outputs clear immediately. The slave transaction is abandoned; the slave's own reset covers it.
- s_ack_i arriving while in IDLE or WRESP is ignored.

Test Plan:
- Reset, then m0 reads adr 32'h0000_0100; slave acks after 40 cycles with 32'hDEADBEEF -> s_adr_o=32'h0000_0100 and m0_ack_o=1 with m0_dat_o=32'hDEADBEEF for one cycle; m1 outputs stay 0.
- m0 and m1 raise read requests in the same cycle with FAIR=1 -> m0 is served first, then m1; repeat the simultaneous requests -> m1 is served first (alternation). With FAIR=0, m0 is served first on every tie.
- m1 requests while m0 is mid-READ -> m1 is granted only after m0's ack plus one idle cycle; gnt_o sequence is 01, 00, 10.
- m1 writes to adr 32'h10 with WRITE_ERR=1 -> m1_err_o pulses for 1 cycle and s_stb_o never asserts. With WRITE_ERR=0 -> m1_ack_o pulses instead.
- Address with upper bits set, 32'hFF12_3456 -> s_adr_o=32'h0012_3456.
- Assert rst 5 cycles into a READ -> all outputs 0 immediately; after release, a new m0 read completes normally.
